// File: rtl/alu_seq_ctrl_if.sv
// Command, ALU and debug bundle for alu_seq_ctrl.
// master: requester/ALU/debug side; slave: the controller.
interface alu_seq_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_kind;
    logic [3:0] cmd_op;
    logic [2:0] cmd_src;
    logic [2:0] cmd_dst;
    logic [7:0] cmd_imm;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_op;
    logic [7:0] alu_y;
    logic       done;
    logic       err;
    logic [7:0] result;
    logic [3:0] flags;
    logic [2:0] dbg_sel;
    logic [7:0] dbg_data;

    modport master (
        output cmd_valid, cmd_kind, cmd_op, cmd_src, cmd_dst, cmd_imm, alu_y, dbg_sel,
        input  cmd_ready, alu_a, alu_b, alu_op, done, err, result, flags, dbg_data
    );

    modport slave (
        input  cmd_valid, cmd_kind, cmd_op, cmd_src, cmd_dst, cmd_imm, alu_y, dbg_sel,
        output cmd_ready, alu_a, alu_b, alu_op, done, err, result, flags, dbg_data
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle sequencer for the 8085 8-bit ALU datapath.
// IDLE -> RD -> EX -> WB; 8x8 register file (B,C,D,E,H,L,M,A) and {S,Z,P,CY} flags.
// Optional macro ALU_SEQ_FWD_EN: accept a new command in WB and go straight WB -> RD.
module alu_seq_ctrl #(
    parameter int unsigned ACC_IDX     = 7,
    parameter logic [7:0]  REG_RST_VAL = 8'h00
) (
    input logic           clk,
    input logic           rst,
    alu_seq_ctrl_if.slave bus
);
    localparam logic [2:0] AccSel = 3'(ACC_IDX);
    localparam logic [3:0] OpTx   = 4'h6;

    typedef enum logic [1:0] {StIdle, StRd, StEx, StWb} state_e;

    state_e     state_q, state_d;
    logic [7:0] regs_q [8];

    logic [1:0] kind_q;
    logic [3:0] op_q;
    logic [2:0] src_q;
    logic [2:0] dst_q;
    logic [7:0] imm_q;
    logic       err_q;

    logic [7:0] alu_a_q, alu_b_q;
    logic [3:0] alu_op_q;
    logic [7:0] result_q;
    logic [3:0] flags_q;

    logic       ready;
    logic       accept;
    logic       cmd_bad;
    logic       flag_upd;
    logic [8:0] sum9;
    logic       cy;
    logic [3:0] flags_new;
    logic [2:0] wr_idx;

    // Next-state logic and command-ready decode
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (bus.cmd_valid) state_d = StRd;
            end
            StRd: state_d = StEx;
            StEx: state_d = StWb;
            StWb: begin
`ifdef ALU_SEQ_FWD_EN
                ready   = 1'b1;
                state_d = bus.cmd_valid ? StRd : StIdle;
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    assign accept  = ready & bus.cmd_valid;
    assign cmd_bad = (bus.cmd_kind == 2'b11) || ((bus.cmd_kind == 2'b00) && bus.cmd_op[3]);

    // Flag computation from the registered operands and the ALU result
    always_comb begin
        sum9 = {1'b0, alu_a_q} + {1'b0, alu_b_q};
        cy   = 1'b0;
        if (alu_op_q == 4'h4)      cy = sum9[8];
        else if (alu_op_q == 4'h5) cy = (alu_a_q < alu_b_q);
        flags_new = {bus.alu_y[7], (bus.alu_y == 8'h00), ~^bus.alu_y, cy};
        flag_upd  = (kind_q == 2'b00) && !err_q && (op_q != OpTx);
        wr_idx    = (kind_q == 2'b00) ? AccSel : dst_q;
    end

    // Command latch, operand staging, result/flag capture and register write-back.
    // With forwarding, the WB write and the next command's latch share an edge, so the
    // following RD already reads the updated register file; no extra bypass path is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= REG_RST_VAL;
            kind_q   <= 2'b00;
            op_q     <= 4'h0;
            src_q    <= 3'd0;
            dst_q    <= 3'd0;
            imm_q    <= 8'h00;
            err_q    <= 1'b0;
            alu_a_q  <= 8'h00;
            alu_b_q  <= 8'h00;
            alu_op_q <= OpTx;
            result_q <= 8'h00;
            flags_q  <= 4'h0;
        end else begin
            if (accept) begin
                kind_q <= bus.cmd_kind;
                op_q   <= bus.cmd_op;
                src_q  <= bus.cmd_src;
                dst_q  <= bus.cmd_dst;
                imm_q  <= bus.cmd_imm;
                err_q  <= cmd_bad;
            end
            if (state_q == StRd) begin
                if (err_q) begin
                    alu_a_q  <= 8'h00;
                    alu_b_q  <= 8'h00;
                    alu_op_q <= OpTx;
                end else begin
                    case (kind_q)
                        2'b00: begin
                            alu_a_q  <= regs_q[AccSel];
                            alu_b_q  <= regs_q[src_q];
                            alu_op_q <= op_q;
                        end
                        2'b10: begin
                            alu_a_q  <= 8'h00;
                            alu_b_q  <= regs_q[src_q];
                            alu_op_q <= OpTx;
                        end
                        default: begin
                            alu_a_q  <= 8'h00;
                            alu_b_q  <= imm_q;
                            alu_op_q <= OpTx;
                        end
                    endcase
                end
            end
            if ((state_q == StEx) && !err_q) begin
                result_q <= bus.alu_y;
                if (flag_upd) flags_q <= flags_new;
            end
            if ((state_q == StWb) && !err_q) regs_q[wr_idx] <= result_q;
        end
    end

    assign bus.cmd_ready = ready;
    assign bus.done      = (state_q == StWb);
    assign bus.err       = (state_q == StWb) & err_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    assign bus.dbg_data  = regs_q[bus.dbg_sel];
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed, table-driven bench for alu_seq_ctrl with a behavioural 8085 ALU.
module tb_alu_seq_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    alu_seq_ctrl_if bus ();

    alu_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU
    always_comb begin
        case (bus.alu_op)
            4'h0:    bus.alu_y = bus.alu_a | bus.alu_b;
            4'h1:    bus.alu_y = bus.alu_a & bus.alu_b;
            4'h2:    bus.alu_y = ~bus.alu_a;
            4'h3:    bus.alu_y = bus.alu_a ^ bus.alu_b;
            4'h4:    bus.alu_y = bus.alu_a + bus.alu_b;
            4'h5:    bus.alu_y = bus.alu_a - bus.alu_b;
            4'h7:    bus.alu_y = bus.alu_a >> bus.alu_b;
            default: bus.alu_y = bus.alu_b;
        endcase
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1);
    end

    typedef struct {
        logic [1:0] kind;
        logic [3:0] op;
        logic [2:0] src;
        logic [2:0] dst;
        logic [7:0] imm;
        logic [2:0] chk_reg;
        logic [7:0] exp_val;
        logic [3:0] exp_flags;
        logic       exp_err;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] mdl [8];
    logic [7:0] last_res;

    function automatic vec_t mk(logic [1:0] k, logic [3:0] op, logic [2:0] src, logic [2:0] dst,
                                logic [7:0] imm, logic [2:0] r, logic [7:0] val,
                                logic [3:0] fl, logic e);
        vec_t v;
        v.kind = k; v.op = op; v.src = src; v.dst = dst; v.imm = imm;
        v.chk_reg = r; v.exp_val = val; v.exp_flags = fl; v.exp_err = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] k, input logic [3:0] op, input logic [2:0] src,
                         input logic [2:0] dst, input logic [7:0] imm);
        bus.cmd_kind = k; bus.cmd_op = op; bus.cmd_src = src;
        bus.cmd_dst = dst; bus.cmd_imm = imm;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   n;
        logic d1, d2;
        @(negedge clk);
        bus.dbg_sel = v.chk_reg;
        drive(v.kind, v.op, v.src, v.dst, v.imm);
        bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("v%0d ready", idx), bus.cmd_ready, 1);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk); d1 = bus.done;
        @(negedge clk); d2 = bus.done;
        @(negedge clk);
        check($sformatf("v%0d latency", idx), {d1, d2, bus.done}, 3'b001);
        check($sformatf("v%0d err", idx), bus.err, v.exp_err);
        check($sformatf("v%0d dbg_old", idx), bus.dbg_data, mdl[v.chk_reg]);
        @(negedge clk);
        check($sformatf("v%0d done_pulse", idx), bus.done, 0);
        if (!v.exp_err) begin
            mdl[v.chk_reg] = v.exp_val;
            last_res       = v.exp_val;
        end
        check($sformatf("v%0d dbg_new", idx), bus.dbg_data, mdl[v.chk_reg]);
        check($sformatf("v%0d result", idx), bus.result, last_res);
        check($sformatf("v%0d flags", idx), bus.flags, v.exp_flags);
    endtask

    initial begin
        int   acc;
        logic busy;
        logic seen;
        checks   = 0;
        failures = 0;
        last_res = 8'h00;
        for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.dbg_sel   = 3'd0;
        drive(2'b00, 4'h0, 3'd0, 3'd0, 8'h00);

        //            kind  op    src   dst   imm    reg   val    flags    err
        vecs.push_back(mk(2'b01, 4'h0, 3'd0, 3'd0, 8'hF0, 3'd0, 8'hF0, 4'b0000, 1'b0));
        vecs.push_back(mk(2'b01, 4'h0, 3'd0, 3'd7, 8'h20, 3'd7, 8'h20, 4'b0000, 1'b0));
        vecs.push_back(mk(2'b00, 4'h4, 3'd0, 3'd0, 8'h00, 3'd7, 8'h10, 4'b0001, 1'b0));
        vecs.push_back(mk(2'b01, 4'h0, 3'd0, 3'd7, 8'h05, 3'd7, 8'h05, 4'b0001, 1'b0));
        vecs.push_back(mk(2'b01, 4'h0, 3'd0, 3'd1, 8'h07, 3'd1, 8'h07, 4'b0001, 1'b0));
        vecs.push_back(mk(2'b00, 4'h5, 3'd1, 3'd0, 8'h00, 3'd7, 8'hFE, 4'b1001, 1'b0));
        vecs.push_back(mk(2'b00, 4'h3, 3'd7, 3'd0, 8'h00, 3'd7, 8'h00, 4'b0110, 1'b0));
        vecs.push_back(mk(2'b10, 4'h0, 3'd0, 3'd3, 8'h00, 3'd3, 8'hF0, 4'b0110, 1'b0));
        vecs.push_back(mk(2'b00, 4'h9, 3'd0, 3'd0, 8'h00, 3'd7, 8'h00, 4'b0110, 1'b1));
        vecs.push_back(mk(2'b11, 4'h0, 3'd0, 3'd7, 8'h55, 3'd7, 8'h00, 4'b0110, 1'b1));
        vecs.push_back(mk(2'b01, 4'h0, 3'd0, 3'd2, 8'h0F, 3'd2, 8'h0F, 4'b0110, 1'b0));
        vecs.push_back(mk(2'b01, 4'h0, 3'd0, 3'd7, 8'h3C, 3'd7, 8'h3C, 4'b0110, 1'b0));
        vecs.push_back(mk(2'b00, 4'h0, 3'd2, 3'd0, 8'h00, 3'd7, 8'h3F, 4'b0010, 1'b0));
        vecs.push_back(mk(2'b00, 4'h6, 3'd0, 3'd0, 8'h00, 3'd7, 8'hF0, 4'b0010, 1'b0));
        vecs.push_back(mk(2'b01, 4'h0, 3'd0, 3'd4, 8'h04, 3'd4, 8'h04, 4'b0010, 1'b0));
        vecs.push_back(mk(2'b00, 4'h7, 3'd4, 3'd0, 8'h00, 3'd7, 8'h0F, 4'b0010, 1'b0));
        vecs.push_back(mk(2'b01, 4'h0, 3'd0, 3'd5, 8'h09, 3'd5, 8'h09, 4'b0010, 1'b0));
        vecs.push_back(mk(2'b00, 4'h7, 3'd5, 3'd0, 8'h00, 3'd7, 8'h00, 4'b0110, 1'b0));
        vecs.push_back(mk(2'b00, 4'h2, 3'd0, 3'd0, 8'h00, 3'd7, 8'hFF, 4'b1010, 1'b0));
        vecs.push_back(mk(2'b00, 4'h5, 3'd4, 3'd0, 8'h00, 3'd7, 8'hFB, 4'b1000, 1'b0));
        vecs.push_back(mk(2'b00, 4'h1, 3'd0, 3'd0, 8'h00, 3'd7, 8'hF0, 4'b1010, 1'b0));
        vecs.push_back(mk(2'b10, 4'h0, 3'd7, 3'd6, 8'h00, 3'd6, 8'hF0, 4'b1010, 1'b0));
        vecs.push_back(mk(2'b00, 4'h4, 3'd0, 3'd0, 8'h00, 3'd7, 8'hE0, 4'b1001, 1'b0));

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        for (int i = 0; i < 8; i++) begin
            bus.dbg_sel = 3'(i);
            #1 check($sformatf("reset dbg[%0d]", i), bus.dbg_data, 8'h00);
        end
        check("reset flags", bus.flags, 4'h0);
        check("reset ready", bus.cmd_ready, 1);
        check("reset done", bus.done, 0);
        check("reset err", bus.err, 0);
        check("reset result", bus.result, 8'h00);
        check("reset alu_op", bus.alu_op, 4'h6);
        check("reset alu_a", bus.alu_a, 8'h00);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // cmd_valid held through the command: exactly one acceptance
        @(negedge clk);
        bus.dbg_sel = 3'd2;
        drive(2'b01, 4'h0, 3'd0, 3'd2, 8'h55);
        bus.cmd_valid = 1'b1;
        acc  = 0;
        busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            if (bus.cmd_valid && bus.cmd_ready) acc++;
            if (i == 1 || i == 2) busy |= bus.cmd_ready;
`ifdef ALU_SEQ_FWD_EN
            if (i == 2) bus.cmd_valid = 1'b0;
`else
            if (i == 3) busy |= bus.cmd_ready;
            if (i == 3) bus.cmd_valid = 1'b0;
`endif
        end
        @(negedge clk);
        check("hold accepts", acc, 1);
        check("hold ready_busy", busy, 0);
        check("hold dbg R2", bus.dbg_data, 8'h55);

        // Reset pulsed during EX of an ADD aborts it
        drive(2'b00, 4'h4, 3'd0, 3'd0, 8'h00);
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b1;
        seen = 1'b0;
        @(negedge clk);
        seen |= bus.done;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen |= bus.done;
        end
        check("abort no_done", seen, 0);
        check("abort ready", bus.cmd_ready, 1);
        check("abort flags", bus.flags, 4'h0);
        check("abort result", bus.result, 8'h00);
        for (int i = 0; i < 8; i++) begin
            bus.dbg_sel = 3'(i);
            #1 check($sformatf("abort dbg[%0d]", i), bus.dbg_data, 8'h00);
        end

`ifdef ALU_SEQ_FWD_EN
        // Back-to-back: LDI A=1 then ADD src7 accepted in the WB cycle
        @(negedge clk);
        bus.dbg_sel = 3'd7;
        drive(2'b01, 4'h0, 3'd0, 3'd7, 8'h01);
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 drive(2'b00, 4'h4, 3'd7, 3'd0, 8'h00);
        repeat (3) @(negedge clk);
        check("fwd first done", bus.done, 1);
        check("fwd ready_in_wb", bus.cmd_ready, 1);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk); d_chk(0);
        @(negedge clk); d_chk(0);
        @(negedge clk);
        check("fwd second done", bus.done, 1);
        @(negedge clk);
        check("fwd A", bus.dbg_data, 8'h02);
        check("fwd flags", bus.flags, 4'b0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

`ifdef ALU_SEQ_FWD_EN
    task automatic d_chk(input logic exp);
        check("fwd done gap", bus.done, exp);
    endtask
`endif
endmodule
